boot_loader_ctrl: RTL



---
 rtl/boot_loader_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/boot_loader_ctrl.sv
// Bootstrap sequencer: receives a framed program image over a byte stream and
// writes it as instruction words into program memory, holding the CPU until verified.
module boot_loader_ctrl #(
    parameter int ADDR_W  = 12,
    parameter int WORD_W  = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              pm_we,
    output logic [ADDR_W-1:0] pm_addr,
    output logic [WORD_W-1:0] pm_wdata,
    output logic              bootstrapping,
    output logic              done,
    output logic              error
);

    localparam int          CNT_W      = $clog2(TIMEOUT + 1);
    localparam logic [7:0]  HDR_BYTE   = 8'hA5;
    localparam logic [CNT_W-1:0] TCNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_CKSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state, state_nxt;
    logic [11:0]       len_q, len_nxt;
    logic [ADDR_W-1:0] word_idx, word_idx_nxt;
    logic [7:0]        hi_q, hi_nxt;
    logic [7:0]        cksum, cksum_nxt;
    logic [CNT_W-1:0]  tcnt, tcnt_nxt;
    logic              we_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [WORD_W-1:0] wdata_nxt;
    logic              receiving;
    logic              accept;
    logic [11:0]       len_full;

    always_comb begin
        receiving = (state == S_HDR)     || (state == S_LEN_HI)  ||
                    (state == S_LEN_LO)  || (state == S_DATA_HI) ||
                    (state == S_DATA_LO) || (state == S_CKSUM);
    end

    assign rx_ready      = receiving;
    assign accept        = rx_valid && receiving;
    assign len_full      = {len_q[11:8], rx_data};
    assign done          = (state == S_DONE);
    assign error         = (state == S_ERR);
    assign bootstrapping = (state != S_DONE);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_nxt    = state;
        len_nxt      = len_q;
        hi_nxt       = hi_q;
        cksum_nxt    = cksum;
        tcnt_nxt     = tcnt;
        we_nxt       = 1'b0;
        addr_nxt     = pm_addr;
        wdata_nxt    = pm_wdata;
        // The index advances in the cycle after the write strobe.
        word_idx_nxt = pm_we ? word_idx + 1'b1 : word_idx;

        if (receiving) begin
            tcnt_nxt = accept ? '0 : tcnt + 1'b1;
        end

        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_nxt    = S_HDR;
                    word_idx_nxt = '0;
                    cksum_nxt    = '0;
                    addr_nxt     = '0;
                    tcnt_nxt     = '0;
                    len_nxt      = '0;
                end
            end
            S_HDR: begin
                if (accept) begin
                    state_nxt = (rx_data == HDR_BYTE) ? S_LEN_HI : S_ERR;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    if (rx_data[7:4] != 4'h0) begin
                        state_nxt = S_ERR;
                    end else begin
                        len_nxt   = {rx_data[3:0], 8'h00};
                        state_nxt = S_LEN_LO;
                    end
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_nxt   = len_full;
                    state_nxt = (len_full == 12'd0) ? S_ERR : S_DATA_HI;
                end
            end
            S_DATA_HI: begin
                if (accept) begin
                    hi_nxt    = rx_data;
                    cksum_nxt = cksum + rx_data;
                    state_nxt = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                if (accept) begin
                    cksum_nxt = cksum + rx_data;
                    we_nxt    = 1'b1;
                    addr_nxt  = word_idx;
                    wdata_nxt = WORD_W'({hi_q, rx_data});
                    state_nxt = (word_idx == ADDR_W'(len_q - 12'd1)) ? S_CKSUM : S_DATA_HI;
                end
            end
            S_CKSUM: begin
                if (accept) begin
                    state_nxt = (rx_data == cksum) ? S_DONE : S_ERR;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // A byte accepted on the last allowed cycle takes precedence over the timeout.
        if (receiving && !accept && (tcnt == TCNT_LAST)) begin
            state_nxt = S_ERR;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            state    <= S_IDLE;
            len_q    <= '0;
            word_idx <= '0;
            hi_q     <= '0;
            cksum    <= '0;
            tcnt     <= '0;
            pm_we    <= 1'b0;
            pm_addr  <= '0;
            pm_wdata <= '0;
        end else begin
            state    <= state_nxt;
            len_q    <= len_nxt;
            word_idx <= word_idx_nxt;
            hi_q     <= hi_nxt;
            cksum    <= cksum_nxt;
            tcnt     <= tcnt_nxt;
            pm_we    <= we_nxt;
            pm_addr  <= addr_nxt;
            pm_wdata <= wdata_nxt;
        end
    end

endmodule
